uart_rx_pkt_ctrl: RTL and testbench
===================================

Name: uart_rx_pkt_ctrl

Overview:
Packet-level controller sitting directly behind the UART receiver. It drives the receiver's enable and consumes its byte strobes (valid, break, data). It hunts for a sync byte, parses length, payload and checksum, and buffers each packet in an internal FIFO. A packet becomes visible on the valid/ready output stream only after its checksum verifies; bad or aborted packets are rolled back and never appear downstream.

Parameters:
SYNC_BYTE, 8'hA5, packet start marker
MAX_LEN, 16, largest legal payload length (1..MAX_LEN); must be <= FIFO_DEPTH
FIFO_DEPTH, 32, payload buffer entries; power of two, >= 2
TIMEOUT_CYCLES, 100000, maximum clk cycles between bytes inside a packet

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
enable  in  1  software enable for reception
rx_valid  in  1  one-cycle byte strobe from UART receiver
rx_break  in  1  break strobe from receiver; qualifies rx_valid
rx_data  in  8  received byte
rx_en  out  1  drives receiver enable; equals registered enable
m_valid  out  1  output byte available (committed data only)
m_ready  in  1  downstream accept
m_data  out  8  output payload byte
m_last  out  1  marks final payload byte of a packet
pkt_ok  out  1  one-cycle pulse: packet committed
pkt_err  out  1  one-cycle pulse: packet dropped
err_code  out  2  valid with pkt_err: 0 checksum, 1 length, 2 timeout/break, 3 overflow
busy  out  1  high in any state other than HUNT

Behaviour:
- Reset (async assert, sync release): state HUNT; all FIFO pointers 0; rx_en=0, m_valid=0, m_last=0, m_data=0, pkt_ok=0, pkt_err=0, err_code=0, busy=0.
- rx_en is enable registered once; a byte strobe is acted on only when rx_valid=1.
- States:
  - HUNT: on rx_data==SYNC_BYTE go to LEN; other bytes ignored; break ignored.
  - LEN: capture len and seed chk=len.
    - len==0 or len>MAX_LEN -> err 1, back to HUNT.
    - len > free space (FIFO_DEPTH - (wr_ptr - rd_ptr)) -> err 3, back to HUNT.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: per byte, write {last, data} at wr_ptr, increment wr_ptr, chk=chk+data (mod 256), cnt++. last=1 when cnt==len-1. After len bytes go to CSUM.
  - CSUM: if (chk+rx_data) mod 256 == 0, commit: cm_ptr=wr_ptr, pkt_ok pulse. Otherwise rewind wr_ptr=cm_ptr and pulse err 0. Either way back to HUNT.
- Timeout: counter clears on each byte and counts in LEN/PAYLOAD/CSUM. At TIMEOUT_CYCLES-1 without a byte: rewind, err 2, back to HUNT.
- rx_valid with rx_break in LEN/PAYLOAD/CSUM: break wins; rewind, err 2, back to HUNT.
- enable deasserted outside HUNT: rewind silently (no pkt_err), back to HUNT.
- Output side:
  - m_valid = (rd_ptr != cm_ptr). m_data/m_last come from rd_ptr.
  - Pop on m_valid && m_ready. m_data/m_last hold stable while m_valid && !m_ready.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Commit and pop in the same cycle are both honoured. A commit makes data visible on m_valid the same cycle pkt_ok is high; latency from CSUM strobe is 1 cycle.
- pkt_ok and pkt_err are never high together.

Optional Feature:
UART_RX_PKT_STATS_EN:
- When defined, adds outputs good_cnt[15:0], bad_cnt[15:0] and input stats_clr.
  - good_cnt increments on pkt_ok; bad_cnt increments on pkt_err; both saturate at 16'hFFFF.
  - stats_clr zeroes both; clear wins over a simultaneous increment.
  - Both reset to 0.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Good packet: A5 03 11 22 33 97, m_ready=1 -> pkt_ok once; m_data 11,22,33 in order; m_last=1 only with 33; err pulses 0.
- Bad checksum: A5 02 10 20 00 -> pkt_err with err_code 0; m_valid stays 0; pointers unchanged; then a good packet passes intact.
- Length error: A5 00 and A5 (MAX_LEN+1) -> err_code 1 each; the following bytes are hunted for A5 again.
- Backpressure and overflow: m_ready=0, send a MAX_LEN packet twice (FIFO_DEPTH=32, MAX_LEN=16) -> both commit; a third gives err_code 3. Raising m_ready drains 32 bytes with m_last on bytes 16 and 32.
- Timeout and break: A5 04 11 then idle TIMEOUT_CYCLES -> err_code 2. A5 04 with rx_break on the next strobe -> err_code 2; no data emitted.
- Abort: drop enable mid-payload -> no pkt_err, busy falls next cycle, rx_en follows enable one cycle later. Async resetn mid-packet -> all outputs are at reset values immediately.

Source files
------------

// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: packet controller behind a UART receiver.
// Frame: SYNC_BYTE, LEN (1..MAX_LEN), LEN payload bytes, checksum byte.
// The frame is valid when (LEN + sum(payload) + checksum) mod 256 == 0.
// Payload is written speculatively into the FIFO. It becomes visible on the
// m_* stream only when the commit pointer advances on a good checksum.
// Any failure or abort rewinds the write pointer back to the commit pointer.
// Optional statistics counters are enabled with the macro UART_RX_PKT_STATS_EN.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         FIFO_DEPTH     = 32,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        rx_valid,
  input  logic        rx_break,
  input  logic [7:0]  rx_data,
  output logic        rx_en,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [1:0]  err_code,
  output logic        busy
`ifdef UART_RX_PKT_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] LEN     = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] CSUM    = 2'd3;

  localparam logic [1:0] ERR_CSUM = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_OVF  = 2'd3;

  // Storage word is {last, data}.
  logic [8:0]    mem_r [FIFO_DEPTH];

  logic [1:0]    state_r, state_s;
  logic [7:0]    len_r, len_s;
  logic [7:0]    chk_r, chk_s;
  logic [7:0]    cnt_r, cnt_s;
  logic [TW-1:0] tmo_r, tmo_s;
  logic [PW-1:0] wr_ptr_r, wr_ptr_s;
  logic [PW-1:0] cm_ptr_r, cm_ptr_s;
  logic [PW-1:0] rd_ptr_r;
  logic          rx_en_r;
  logic          pkt_ok_r, ok_s;
  logic          pkt_err_r, err_s;
  logic [1:0]    err_code_r, code_s;
  logic          we_s;
  logic [8:0]    wdata_s;
  logic          last_s;
  logic [7:0]    sum_s;
  logic [PW-1:0] used_s;
  logic [15:0]   free_s;
  logic [8:0]    rd_word_s;
  logic          pop_s;

  // Space check: occupied entries include committed and speculative data.
  assign used_s  = wr_ptr_r - rd_ptr_r;
  assign free_s  = 16'(FIFO_DEPTH) - 16'(used_s);
  assign last_s  = (cnt_r == (len_r - 8'd1));
  assign sum_s   = chk_r + rx_data;

  // Output stream: only data below the commit pointer is ever visible.
  assign rd_word_s = mem_r[rd_ptr_r[AW-1:0]];
  assign m_valid   = (rd_ptr_r != cm_ptr_r);
  assign m_data    = m_valid ? rd_word_s[7:0] : 8'h00;
  assign m_last    = m_valid ? rd_word_s[8] : 1'b0;
  assign pop_s     = m_valid && m_ready;

  assign rx_en     = rx_en_r;
  assign pkt_ok    = pkt_ok_r;
  assign pkt_err   = pkt_err_r;
  assign err_code  = err_code_r;
  assign busy      = (state_r != HUNT);

  // Next-state, checksum, pointer and error decode for the packet parser.
  always_comb begin
    state_s  = state_r;
    len_s    = len_r;
    chk_s    = chk_r;
    cnt_s    = cnt_r;
    tmo_s    = tmo_r;
    wr_ptr_s = wr_ptr_r;
    cm_ptr_s = cm_ptr_r;
    ok_s     = 1'b0;
    err_s    = 1'b0;
    code_s   = 2'd0;
    we_s     = 1'b0;
    wdata_s  = 9'd0;
    if (state_r == HUNT) begin
      tmo_s = {TW{1'b0}};
      if (enable && rx_valid && !rx_break && (rx_data == SYNC_BYTE)) begin
        state_s = LEN;
      end else begin
        state_s = HUNT;
      end
    end else if (!enable) begin
      // Software abort: drop the speculative data without reporting it.
      wr_ptr_s = cm_ptr_r;
      tmo_s    = {TW{1'b0}};
      state_s  = HUNT;
    end else if (rx_valid && rx_break) begin
      wr_ptr_s = cm_ptr_r;
      tmo_s    = {TW{1'b0}};
      err_s    = 1'b1;
      code_s   = ERR_TMO;
      state_s  = HUNT;
    end else if (rx_valid) begin
      tmo_s = {TW{1'b0}};
      case (state_r)
        LEN: begin
          len_s = rx_data;
          chk_s = rx_data;
          cnt_s = 8'd0;
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            err_s   = 1'b1;
            code_s  = ERR_LEN;
            state_s = HUNT;
          end else if ({8'd0, rx_data} > free_s) begin
            err_s   = 1'b1;
            code_s  = ERR_OVF;
            state_s = HUNT;
          end else begin
            state_s = PAYLOAD;
          end
        end
        PAYLOAD: begin
          we_s     = 1'b1;
          wdata_s  = {last_s, rx_data};
          wr_ptr_s = wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
          chk_s    = sum_s;
          cnt_s    = cnt_r + 8'd1;
          if (last_s) begin
            state_s = CSUM;
          end else begin
            state_s = PAYLOAD;
          end
        end
        CSUM: begin
          if (sum_s == 8'd0) begin
            cm_ptr_s = wr_ptr_r;
            ok_s     = 1'b1;
          end else begin
            wr_ptr_s = cm_ptr_r;
            err_s    = 1'b1;
            code_s   = ERR_CSUM;
          end
          state_s = HUNT;
        end
        default: begin
          wr_ptr_s = cm_ptr_r;
          state_s  = HUNT;
        end
      endcase
    end else if (tmo_r == TMO_LAST) begin
      wr_ptr_s = cm_ptr_r;
      tmo_s    = {TW{1'b0}};
      err_s    = 1'b1;
      code_s   = ERR_TMO;
      state_s  = HUNT;
    end else begin
      tmo_s = tmo_r + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // Control and pointer registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= HUNT;
      len_r      <= 8'd0;
      chk_r      <= 8'd0;
      cnt_r      <= 8'd0;
      tmo_r      <= {TW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      cm_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      rx_en_r    <= 1'b0;
      pkt_ok_r   <= 1'b0;
      pkt_err_r  <= 1'b0;
      err_code_r <= 2'd0;
    end else begin
      state_r    <= state_s;
      len_r      <= len_s;
      chk_r      <= chk_s;
      cnt_r      <= cnt_s;
      tmo_r      <= tmo_s;
      wr_ptr_r   <= wr_ptr_s;
      cm_ptr_r   <= cm_ptr_s;
      rx_en_r    <= enable;
      pkt_ok_r   <= ok_s;
      pkt_err_r  <= err_s;
      err_code_r <= code_s;
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Payload storage; speculative writes never touch committed entries.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata_s;
    end
  end

`ifdef UART_RX_PKT_STATS_EN
  // Saturating good/bad packet counters; clear has priority.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      good_cnt <= 16'd0;
      bad_cnt  <= 16'd0;
    end else if (stats_clr) begin
      good_cnt <= 16'd0;
      bad_cnt  <= 16'd0;
    end else begin
      if (pkt_ok_r && (good_cnt != 16'hFFFF)) begin
        good_cnt <= good_cnt + 16'd1;
      end
      if (pkt_err_r && (bad_cnt != 16'hFFFF)) begin
        bad_cnt <= bad_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed self-checking bench for uart_rx_pkt_ctrl (default build).
module tb_uart_rx_pkt_ctrl;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_break = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_en;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_last;
  logic        pkt_ok;
  logic        pkt_err;
  logic [1:0]  err_code;
  logic        busy;
`ifdef UART_RX_PKT_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
`endif

  uart_rx_pkt_ctrl #(
    .SYNC_BYTE(8'hA5), .MAX_LEN(16), .FIFO_DEPTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .rx_valid(rx_valid), .rx_break(rx_break), .rx_data(rx_data),
    .rx_en(rx_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code), .busy(busy)
`ifdef UART_RX_PKT_STATS_EN
    , .stats_clr(stats_clr), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ok_seen  = 0;
  int         err_seen = 0;
  int         both_seen = 0;
  logic [1:0] last_err = 2'd0;
  logic [8:0] popped[$];

  // Observe pulses and accepted output words away from the active edge.
  always @(negedge clk) begin
    if (pkt_ok) ok_seen++;
    if (pkt_err) begin
      err_seen++;
      last_err = err_code;
    end
    if (pkt_ok && pkt_err) both_seen++;
    if (m_valid && m_ready) popped.push_back({m_last, m_data});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic brk);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = b; rx_break = brk;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_break = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_word(input string tag, input logic [8:0] exp);
    logic [8:0] w;
    if (popped.size() > 0) w = popped.pop_front();
    else w = 9'h1FF;
    check_val(tag, 32'(w), 32'(exp));
  endtask

  int ok0, err0;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while held in reset with enable already high.
    enable = 1'b1;
    idle(3);
    check_val("rst_rx_en", 32'(rx_en), 32'd0);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_pulses", 32'({pkt_ok, pkt_err, err_code}), 32'd0);
    check_val("rst_mdata", 32'({m_last, m_data}), 32'd0);
    #3 resetn = 1'b1;
    idle(2);
    check_val("rx_en_on", 32'(rx_en), 32'd1);

    // Good packet with m_ready high.
    ok0 = ok_seen; err0 = err_seen;
    send_byte(8'hA5, 1'b0);
    check_val("busy_after_sync", 32'(busy), 32'd1);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    check_val("no_early_valid", 32'(m_valid), 32'd0);
    send_byte(8'h97, 1'b0);
    check_val("commit_pkt_ok", 32'(pkt_ok), 32'd1);
    check_val("commit_m_valid", 32'(m_valid), 32'd1);
    check_val("commit_m_data", 32'(m_data), 32'h11);
    idle(5);
    check_val("good_ok_cnt", 32'(ok_seen - ok0), 32'd1);
    check_val("good_err_cnt", 32'(err_seen - err0), 32'd0);
    check_val("good_nwords", 32'(popped.size()), 32'd3);
    pop_word("good_w0", {1'b0, 8'h11});
    pop_word("good_w1", {1'b0, 8'h22});
    pop_word("good_w2", {1'b1, 8'h33});

    // Bad checksum, then a good one-byte packet.
    ok0 = ok_seen; err0 = err_seen;
    send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0);
    send_byte(8'h00, 1'b0);
    check_val("csum_err_pulse", 32'(pkt_err), 32'd1);
    check_val("csum_err_code", 32'(err_code), 32'd0);
    check_val("csum_no_ok", 32'(pkt_ok), 32'd0);
    idle(3);
    check_val("csum_m_valid", 32'(m_valid), 32'd0);
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h44, 1'b0); send_byte(8'hBB, 1'b0);
    idle(3);
    check_val("csum_ok_cnt", 32'(ok_seen - ok0), 32'd1);
    check_val("csum_err_cnt", 32'(err_seen - err0), 32'd1);
    check_val("csum_nwords", 32'(popped.size()), 32'd1);
    pop_word("after_bad_w0", {1'b1, 8'h44});

    // Length errors: zero and MAX_LEN+1; trailing bytes are hunted over.
    ok0 = ok_seen; err0 = err_seen;
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0);
    check_val("len0_err", 32'({pkt_err, err_code}), 32'({1'b1, 2'd1}));
    send_byte(8'hA5, 1'b0); send_byte(8'h11, 1'b0);
    check_val("len17_err", 32'({pkt_err, err_code}), 32'({1'b1, 2'd1}));
    send_byte(8'h01, 1'b0); send_byte(8'h44, 1'b0); send_byte(8'hBB, 1'b0);
    idle(3);
    check_val("len_busy", 32'(busy), 32'd0);
    check_val("len_ok_cnt", 32'(ok_seen - ok0), 32'd0);
    check_val("len_err_cnt", 32'(err_seen - err0), 32'd2);
    check_val("len_nwords", 32'(popped.size()), 32'd0);

    // Backpressure: two MAX_LEN packets fill the FIFO, third overflows.
    m_ready = 1'b0;
    for (int p = 0; p < 2; p++) begin
      send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0);
      for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 1'b0);
      send_byte(8'h68, 1'b0);
      check_val("full_pkt_ok", 32'(pkt_ok), 32'd1);
    end
    send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0);
    check_val("ovf_err", 32'({pkt_err, err_code}), 32'({1'b1, 2'd3}));
    idle(4);
    check_val("hold_valid", 32'(m_valid), 32'd1);
    check_val("hold_data", 32'({m_last, m_data}), 32'h001);
    m_ready = 1'b1;
    idle(40);
    check_val("drain_valid", 32'(m_valid), 32'd0);
    check_val("drain_nwords", 32'(popped.size()), 32'd32);
    for (int i = 0; i < 32; i++) begin
      pop_word("drain_word", {((i % 16) == 15), 8'((i % 16) + 1)});
    end

    // Timeout mid-payload.
    ok0 = ok_seen; err0 = err_seen;
    send_byte(8'hA5, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h11, 1'b0);
    idle(30);
    check_val("tmo_still_busy", 32'(busy), 32'd1);
    check_val("tmo_no_err_yet", 32'(err_seen - err0), 32'd0);
    idle(50);
    check_val("tmo_err_cnt", 32'(err_seen - err0), 32'd1);
    check_val("tmo_err_code", 32'(last_err), 32'd2);
    check_val("tmo_busy", 32'(busy), 32'd0);

    // Break inside a packet.
    send_byte(8'hA5, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'h11, 1'b1);
    check_val("brk_err", 32'({pkt_err, err_code}), 32'({1'b1, 2'd2}));
    idle(3);
    check_val("brk_busy", 32'(busy), 32'd0);
    check_val("tmo_brk_nwords", 32'(popped.size()), 32'd0);
    check_val("never_both", 32'(both_seen), 32'd0);

    // Enable drop mid-payload: silent abort.
    err0 = err_seen;
    send_byte(8'hA5, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    @(posedge clk); #1 enable = 1'b0;
    check_val("abort_rx_en_lag", 32'(rx_en), 32'd1);
    check_val("abort_busy_lag", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_rx_en", 32'(rx_en), 32'd0);
    check_val("abort_no_err", 32'(pkt_err), 32'd0);
    enable = 1'b1;
    idle(3);
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h44, 1'b0); send_byte(8'hBB, 1'b0);
    idle(3);
    check_val("abort_err_cnt", 32'(err_seen - err0), 32'd0);
    check_val("abort_nwords", 32'(popped.size()), 32'd1);
    pop_word("abort_then_w0", {1'b1, 8'h44});

    // Asynchronous reset mid-packet with committed data pending.
    m_ready = 1'b0;
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h44, 1'b0); send_byte(8'hBB, 1'b0);
    send_byte(8'hA5, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h11, 1'b0);
    check_val("pre_rst_state", 32'({m_valid, busy, rx_en}), 32'h7);
    #2 resetn = 1'b0;
    #1;
    check_val("arst_ctrl", 32'({m_valid, busy, rx_en, pkt_ok, pkt_err}), 32'd0);
    check_val("arst_data", 32'({m_last, m_data, err_code}), 32'd0);
    idle(2);
    #2 resetn = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
